fill_checker: RTL
=================

Name: fill_checker

Overview:
- AXI4 read master that reads back the BRAM region written by the fill engine.
- Checks that the region holds sequential 32-bit integers: byte address A holds value A/4 in each 32-bit lane.
- Reports pass/fail, an error count and the first failing address to the host side.
- Sits on the same AXI interconnect port as the fill engine, on the read channels only.

Parameters:
- IW, 2, AXI ID width.
- AW, 20, AXI address width.
- DW, 512, AXI data width. Fixed at 512, giving 16 lanes of 32 bits.
- BRAM_SIZE, 32'h10_0000, bytes to check. Must be a multiple of 256.
- MAX_OUTSTANDING, 8, maximum AR bursts issued whose RLAST has not yet returned. Range 1..255.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a check. Ignored while busy.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the final beat is checked.
- pass  out  1  valid from done until the next start: 1 if error_count==0 and rlast_err==0.
- error_count  out  32  number of mismatching beats. Saturates at 32'hFFFF_FFFF.
- first_err_valid  out  1  a mismatch has been recorded this run.
- first_err_addr  out  AW  byte address of the first mismatching beat.
- rlast_err  out  1  sticky flag: RLAST was seen on a wrong beat or was missing on beat 3.
- M_AXI_ARADDR/ARVALID/ARREADY/ARLEN/ARSIZE/ARBURST/ARID/ARLOCK/ARCACHE/ARQOS/ARPROT: standard AXI4 AR channel; master drives, slave returns ARREADY.
- M_AXI_RDATA/RID/RRESP/RLAST/RVALID/RREADY: standard AXI4 R channel; slave drives, master returns RREADY.
- AW, W and B channels are not present on this block.

Behaviour:
- Constants:
  - Burst = 256 bytes = 4 beats.
  - ARLEN=3, ARSIZE=6, ARBURST=1 (INCR).
  - ARID, ARLOCK, ARCACHE, ARQOS, ARPROT = 0.
  - TOTAL_BURSTS = BRAM_SIZE/256. TOTAL_BEATS = BRAM_SIZE/64.
- Reset values: ARVALID=0, RREADY=0, busy=0, done=0, pass=0, error_count=0, first_err_valid=0, first_err_addr=0, rlast_err=0, ARADDR=0, all counters 0.
- Reset mid-run: all state returns to IDLE on the next edge. No further AR is issued. Slave responses still in flight are the integrator's responsibility.
- Top FSM:
  - IDLE -> RUN on start. In that cycle, clear error_count, first_err_valid, first_err_addr, rlast_err, pass, the AR address, the expected value and the beat counters.
  - RUN -> DONE when the R handshake of the final beat (beat TOTAL_BEATS-1) completes.
  - DONE lasts one cycle: done=1, pass computed, then -> IDLE.
  - start in RUN or DONE is ignored.
- AR path:
  - ARVALID=1 in RUN while ar_issued < TOTAL_BURSTS and outstanding < MAX_OUTSTANDING.
  - ARVALID and ARADDR hold stable until ARREADY.
  - On handshake: ARADDR += 256, ar_issued++.
  - First ARVALID appears the cycle after start is accepted.
- Outstanding counter:
  - +1 on AR handshake.
  - -1 on an R handshake where RLAST=1 or beat_in_burst==3.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- R path:
  - RREADY=1 throughout RUN, 0 otherwise.
  - Each R handshake is one beat:
    - lane i is expected to equal expected+i, for i = 0..15;
    - the beat mismatches if any lane differs or RRESP != 0;
    - on mismatch, error_count++ (saturating);
    - on the first mismatch, first_err_addr = beat_index*64 and first_err_valid=1.
  - After each beat: expected += 16, beat_index++, beat_in_burst wraps mod 4.
  - RLAST must be 1 exactly when beat_in_burst==3; otherwise set rlast_err. Burst framing always follows the beat count, never RLAST.
- Outputs are registered. Compare result takes effect 1 cycle after the handshake, and is final before done is asserted.
- RID is ignored. Responses are in order with a single ID.

Test Plan:
- Memory model preloaded with word[n]=n, BRAM_SIZE=0x10_0000, ARREADY and RVALID always 1 -> 4096 AR bursts with ARADDR 0x0..0xFFF00; done once; pass=1; error_count=0; first_err_valid=0.
- Same, but lane 5 of beat 1000 corrupted to 0xDEADBEEF, and lane 0 of beat 2000 corrupted -> error_count=2, first_err_addr=0xFA00, pass=0.
- RRESP=2'b10 on beat 7 with correct data -> error_count=1, first_err_addr=0x1C0.
- ARREADY random 30%, slave latency 20 cycles, RVALID random -> outstanding never >8, ARADDR stable while stalled, pass=1.
- RLAST asserted on beat 1 of burst 3 -> rlast_err=1, pass=0, beat count unaffected, done still fires after 16384 beats.
- start pulsed at cycle 100 of a run -> ignored, and no extra AR is issued. resetn low mid-run -> next cycle ARVALID=0, busy=0; a new start then gives a full clean run with pass=1.

Source files
------------

// File: rtl/fill_checker.sv
// fill_checker: AXI4 read master that verifies a BRAM region holds sequential 32-bit words
// (byte address A holds A/4) and reports pass/fail, error count and first failing address.
module fill_checker #(
    parameter int          IW              = 2,
    parameter int          AW              = 20,
    parameter int          DW              = 512,
    parameter logic [31:0] BRAM_SIZE       = 32'h10_0000,
    parameter int          MAX_OUTSTANDING = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [31:0]   error_count,
    output logic          first_err_valid,
    output logic [AW-1:0] first_err_addr,
    output logic          rlast_err,
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    output logic [7:0]    M_AXI_ARLEN,
    output logic [2:0]    M_AXI_ARSIZE,
    output logic [1:0]    M_AXI_ARBURST,
    output logic [IW-1:0] M_AXI_ARID,
    output logic          M_AXI_ARLOCK,
    output logic [3:0]    M_AXI_ARCACHE,
    output logic [3:0]    M_AXI_ARQOS,
    output logic [2:0]    M_AXI_ARPROT,
    input  logic [DW-1:0] M_AXI_RDATA,
    input  logic [IW-1:0] M_AXI_RID,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RLAST,
    input  logic          M_AXI_RVALID,
    output logic          M_AXI_RREADY
);
    localparam logic [31:0] TOTAL_BURSTS = BRAM_SIZE >> 8;
    localparam logic [31:0] TOTAL_BEATS  = BRAM_SIZE >> 6;
    localparam logic [8:0]  MAX_OUT      = 9'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t r_state, w_next;

    logic [AW-1:0] r_araddr, r_first_addr, w_beat_addr;
    logic          r_arvalid, r_rready, r_busy, r_done, r_pass, r_first_valid, r_rlast_err;
    logic [31:0]   r_err_cnt, r_ar_issued, r_beat_idx, r_expected;
    logic [31:0]   w_issued_next, w_err_next;
    logic [8:0]    r_outstanding, w_out_next;
    logic [1:0]    r_bib;
    logic          w_ar_hs, w_r_hs, w_burst_end, w_last_beat, w_lane_mis, w_err_inc, w_rlast_bad;
    logic          w_unused_rid;

    assign w_ar_hs       = M_AXI_ARVALID && M_AXI_ARREADY;
    assign w_r_hs        = M_AXI_RVALID && M_AXI_RREADY;
    assign w_burst_end   = w_r_hs && (M_AXI_RLAST || r_bib == 2'd3);
    assign w_last_beat   = w_r_hs && r_beat_idx == TOTAL_BEATS - 32'd1;
    assign w_rlast_bad   = w_r_hs && (M_AXI_RLAST != (r_bib == 2'd3));
    assign w_issued_next = r_ar_issued + (w_ar_hs ? 32'd1 : 32'd0);
    // Simultaneous issue and completion cancel; completion never drops below zero.
    assign w_out_next    = (w_ar_hs && !w_burst_end) ? r_outstanding + 9'd1 :
                           (!w_ar_hs && w_burst_end && r_outstanding != 9'd0) ? r_outstanding - 9'd1 :
                           r_outstanding;
    assign w_beat_addr   = AW'({r_beat_idx, 6'd0});
    assign w_unused_rid  = ^M_AXI_RID;

    always_comb begin
        w_lane_mis = 1'b0;
        for (int i = 0; i < 16; i++)
            w_lane_mis = w_lane_mis | (M_AXI_RDATA[i*32 +: 32] != r_expected + 32'(i));
    end

    assign w_err_inc  = w_r_hs && (w_lane_mis || M_AXI_RRESP != 2'b00);
    assign w_err_next = (w_err_inc && r_err_cnt != 32'hFFFF_FFFF) ? r_err_cnt + 32'd1 : r_err_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last_beat ? S_DONE : S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_araddr      <= '0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err_cnt     <= '0;
            r_first_valid <= 1'b0;
            r_first_addr  <= '0;
            r_rlast_err   <= 1'b0;
            r_ar_issued   <= '0;
            r_outstanding <= '0;
            r_beat_idx    <= '0;
            r_bib         <= '0;
            r_expected    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_araddr      <= '0;
                    r_arvalid     <= 1'b1;
                    r_rready      <= 1'b1;
                    r_busy        <= 1'b1;
                    r_pass        <= 1'b0;
                    r_err_cnt     <= '0;
                    r_first_valid <= 1'b0;
                    r_first_addr  <= '0;
                    r_rlast_err   <= 1'b0;
                    r_ar_issued   <= '0;
                    r_outstanding <= '0;
                    r_beat_idx    <= '0;
                    r_bib         <= '0;
                    r_expected    <= '0;
                end
                S_RUN: begin
                    if (w_ar_hs) r_araddr <= r_araddr + AW'(256);
                    r_ar_issued   <= w_issued_next;
                    r_outstanding <= w_out_next;
                    r_arvalid     <= !w_last_beat && w_issued_next < TOTAL_BURSTS && w_out_next < MAX_OUT;
                    r_err_cnt     <= w_err_next;
                    if (w_r_hs) begin
                        r_expected <= r_expected + 32'd16;
                        r_beat_idx <= r_beat_idx + 32'd1;
                        r_bib      <= r_bib + 2'd1;
                    end
                    if (w_err_inc && !r_first_valid) begin
                        r_first_valid <= 1'b1;
                        r_first_addr  <= w_beat_addr;
                    end
                    if (w_rlast_bad) r_rlast_err <= 1'b1;
                    if (w_last_beat) begin
                        r_busy   <= 1'b0;
                        r_rready <= 1'b0;
                        r_done   <= 1'b1;
                        r_pass   <= w_err_next == 32'd0 && !r_rlast_err && !w_rlast_bad;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign error_count     = r_err_cnt;
    assign first_err_valid = r_first_valid;
    assign first_err_addr  = r_first_addr;
    assign rlast_err       = r_rlast_err;
    assign M_AXI_ARADDR    = r_araddr;
    assign M_AXI_ARVALID   = r_arvalid;
    assign M_AXI_RREADY    = r_rready;
    assign M_AXI_ARLEN     = 8'd3;
    assign M_AXI_ARSIZE    = 3'd6;
    assign M_AXI_ARBURST   = 2'd1;
    assign M_AXI_ARID      = '0;
    assign M_AXI_ARLOCK    = 1'b0;
    assign M_AXI_ARCACHE   = 4'd0;
    assign M_AXI_ARQOS     = 4'd0;
    assign M_AXI_ARPROT    = 3'd0;
endmodule
